// File: rtl/calc_x_y_r_theta.sv
// Polar-to-rectangular converter: x = r*cos(theta), y = r*sin(theta), 15-degree steps.
// One shift-add multiplier is shared by both axes, so a conversion takes a fixed 17 cycles.
module calc_x_y_r_theta (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] r,
  input  logic [3:0] theta,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic [16:0] acc;
  logic [16:0] acc_sum;
  logic [16:0] addend;
  logic [7:0]  r_lat;
  logic [8:0]  cos_lat, sin_lat;
  logic [8:0]  cos_sel, sin_sel;
  logic [8:0]  coef;
  logic        err_lat;
  logic        err_sel;
  logic [7:0]  x_hold;

  // cos/sin scaled by 256; indices beyond 90 degrees give zero and flag an error
  always_comb begin
    cos_sel = 9'd0;
    sin_sel = 9'd0;
    err_sel = 1'b0;
    case (theta)
      4'd0: begin cos_sel = 9'd256; sin_sel = 9'd0;   end
      4'd1: begin cos_sel = 9'd247; sin_sel = 9'd66;  end
      4'd2: begin cos_sel = 9'd222; sin_sel = 9'd128; end
      4'd3: begin cos_sel = 9'd181; sin_sel = 9'd181; end
      4'd4: begin cos_sel = 9'd128; sin_sel = 9'd222; end
      4'd5: begin cos_sel = 9'd66;  sin_sel = 9'd247; end
      4'd6: begin cos_sel = 9'd0;   sin_sel = 9'd256; end
      default: err_sel = 1'b1;
    endcase
  end

  always_comb begin
    coef    = (state == MUL_X) ? cos_lat : sin_lat;
    addend  = {8'd0, coef} << cnt;
    acc_sum = r_lat[cnt] ? (acc + addend) : acc;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL_X;
      MUL_X:   if (cnt == 3'd7) state_next = MUL_Y;
      MUL_Y:   if (cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  assign busy = (state == MUL_X) || (state == MUL_Y);

  // Operands are latched on accept so input changes mid-conversion are ignored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 3'd0;
      acc     <= 17'd0;
      r_lat   <= 8'd0;
      cos_lat <= 9'd0;
      sin_lat <= 9'd0;
      err_lat <= 1'b0;
      x_hold  <= 8'd0;
      done    <= 1'b0;
      x       <= 8'd0;
      y       <= 8'd0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r_lat   <= r;
            cos_lat <= cos_sel;
            sin_lat <= sin_sel;
            err_lat <= err_sel;
            acc     <= 17'd0;
            cnt     <= 3'd0;
          end
        end
        MUL_X: begin
          if (cnt == 3'd7) begin
            x_hold <= acc_sum[15:8];
            acc    <= 17'd0;
            cnt    <= 3'd0;
          end else begin
            acc <= acc_sum;
            cnt <= cnt + 3'd1;
          end
        end
        MUL_Y: begin
          acc <= acc_sum;
          cnt <= cnt + 3'd1;
        end
        DONE: begin
          x    <= x_hold;
          y    <= acc[15:8];
          err  <= err_lat;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_x_y_r_theta.sv
// Directed bench for calc_x_y_r_theta with hand-computed x/y results.
module tb_calc_x_y_r_theta;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] r;
  logic [3:0] theta;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [7:0] y;
  logic       err;

  int checkCount;
  int passCount;

  calc_x_y_r_theta dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .r       (r),
    .theta   (theta),
    .busy    (busy),
    .done    (done),
    .x       (x),
    .y       (y),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Pulses start for one cycle, waits for done, checks latency, busy width and results.
  // With disturb set, start is toggled and r/theta changed while the conversion runs.
  task automatic applyStimulus(input string tag, input logic [7:0] rv, input logic [3:0] tv,
                               input int expX, input int expY, input int expErr,
                               input bit disturb);
    int cycles;
    int busyCycles;
    @(negedge clock);
    r     = rv;
    theta = tv;
    start = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    cycles     = 0;
    busyCycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busyCycles++;
      if (disturb && cycles >= 2 && cycles <= 10) begin
        start = ~start;
        r     = 8'd7;
        theta = 4'd0;
      end
      if (disturb && cycles == 11) start = 1'b0;
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, 17);
    checkOutput({tag, " busy"}, busyCycles, 16);
    checkOutput({tag, " x"}, int'(x), expX);
    checkOutput({tag, " y"}, int'(y), expY);
    checkOutput({tag, " err"}, int'(err), expErr);
    @(posedge clock);
    #1;
    checkOutput({tag, " done width"}, int'(done), 0);
  endtask

  initial begin
    int cycles;
    int gap;
    int seenDone;
    checkCount = 0;
    passCount  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    r       = 8'd0;
    theta   = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset x", int'(x), 0);
    checkOutput("reset y", int'(y), 0);
    checkOutput("reset err", int'(err), 0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("r100 t0", 8'd100, 4'd0, 100, 0,   0, 1'b0);
    applyStimulus("r100 t2", 8'd100, 4'd2, 86,  50,  0, 1'b0);
    applyStimulus("r40 t1",  8'd40,  4'd1, 38,  10,  0, 1'b0);
    applyStimulus("r255 t3", 8'd255, 4'd3, 180, 180, 0, 1'b0);
    applyStimulus("r200 t6", 8'd200, 4'd6, 0,   200, 0, 1'b0);
    applyStimulus("r0 t4",   8'd0,   4'd4, 0,   0,   0, 1'b0);
    applyStimulus("r255 t0", 8'd255, 4'd0, 255, 0,   0, 1'b0);
    applyStimulus("r77 t9",  8'd77,  4'd9, 0,   0,   1, 1'b0);
    applyStimulus("err clr", 8'd40,  4'd1, 38,  10,  0, 1'b0);
    applyStimulus("disturb", 8'd100, 4'd2, 86,  50,  0, 1'b1);

    // Continuous start: done pulses must be 18 cycles apart
    @(negedge clock);
    r     = 8'd100;
    theta = 4'd2;
    start = 1'b1;
    cycles = 0;
    gap    = 0;
    seenDone = 0;
    while (seenDone < 2 && cycles < 80) begin
      @(posedge clock);
      #1;
      cycles++;
      if (seenDone == 1) gap++;
      if (done) begin
        seenDone++;
        checkOutput("stream x", int'(x), 86);
        checkOutput("stream y", int'(y), 50);
      end
    end
    start = 1'b0;
    checkOutput("stream pulses", seenDone, 2);
    checkOutput("stream gap", gap, 18);
    repeat (2) @(posedge clock);

    // Reset 5 cycles into a conversion
    @(negedge clock);
    r     = 8'd200;
    theta = 4'd2;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst busy", int'(busy), 0);
    checkOutput("midrst done", int'(done), 0);
    checkOutput("midrst x", int'(x), 0);
    checkOutput("midrst y", int'(y), 0);
    checkOutput("midrst err", int'(err), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seenDone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (done) seenDone++;
    end
    checkOutput("midrst no done", seenDone, 0);
    applyStimulus("r100 t5", 8'd100, 4'd5, 25, 96, 0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/calc_x_y_r_theta.md
# calc_x_y_r_theta

Sequential polar-to-rectangular converter for the FPGA Phone Home location path. It takes a range `r` and a 15° angle index `theta`, and produces the rectangular coordinates `x = r*cos(theta)` and `y = r*sin(theta)` in the same 8-bit distance units. It is the inverse of the R-from-Y/theta calculation. A single shared shift-add multiplier is reused across both axes, so one conversion takes a fixed 17 cycles under a start/busy/done handshake.

## Interface
Parameters:
- none; all widths and coefficients are fixed.

Ports:
- `clock`: input, 1 bit. System clock; all state updates on the rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Request a conversion. It is a level, sampled only in IDLE.
- `r`: input, 8 bits. Range, unsigned, captured on the accepting edge.
- `theta`: input, 4 bits. Angle index; 0..6 maps to 0°, 15°, …, 90°. Captured on the accepting edge.
- `busy`: output, 1 bit. High while in MUL_X or MUL_Y.
- `done`: output, 1 bit. One-cycle pulse when `x`, `y` and `err` are updated.
- `x`: output, 8 bits. Registered result `r*cos >> 8`.
- `y`: output, 8 bits. Registered result `r*sin >> 8`.
- `err`: output, 1 bit. Set when the captured `theta` is greater than 6. Updated with `done`.

## Operation
Coefficients are cos/sin scaled by 256, 9 bits unsigned. The captured `theta` selects the pair (cos, sin):
- 0 → (256, 0)
- 1 → (247, 66)
- 2 → (222, 128)
- 3 → (181, 181)
- 4 → (128, 222)
- 5 → (66, 247)
- 6 → (0, 256)
- 7..15 → (0, 0), and `err` is set to 1

State machine: IDLE → MUL_X → MUL_Y → DONE → IDLE.
- **IDLE:** if `start`=1, latch `r`, the cos/sin pair and the err flag; clear the 17-bit accumulator and the 3-bit bit counter; go to MUL_X.
- **MUL_X:** 8 cycles. Each cycle, if bit `cnt` of the latched `r` is 1, add `cos << cnt` to the accumulator; increment `cnt`.
  - On `cnt`=7, store `acc[15:8]` into an internal x hold register, clear the accumulator and `cnt`, and go to MUL_Y.
- **MUL_Y:** same as MUL_X using sin. On `cnt`=7, go to DONE.
- **DONE:** load `x` from the hold register, `y` from `acc[15:8]`, `err` from the latch; assert `done`; go to IDLE unconditionally.

Arithmetic rules:
- The product is at most 255×256 = 65280, which fits in 17 bits.
- The result is `product >> 8`, truncated with no rounding.
- Because the result is at most `r`, no saturation is needed.

Reset and hold behaviour:
- All outputs reset to 0: `busy`=0, `done`=0, `x`=0, `y`=0, `err`=0. State resets to IDLE.
- `x`, `y` and `err` hold their last values until the next DONE.

## Timing
- Accepting edge is N (IDLE with `start`=1). `busy` is high from just after edge N through edge N+16.
- `done`, `x`, `y` and `err` update on edge N+17; `done` stays high for exactly one cycle.
- Latency is 17 cycles from the sampled `start` to `done`.
- Throughput is one conversion per 18 cycles, since the next accept can occur at edge N+18.
- `start` is ignored in MUL_X, MUL_Y and DONE. No queuing: a `start` level still high in IDLE after DONE begins a new conversion.
- Changes to `r`/`theta` after the accepting edge have no effect on the running conversion.
- Asserting `reset_n` mid-conversion immediately forces IDLE and zeroes all outputs, with no `done` pulse. After release, the first conversion completes normally.

## Test plan
- `r`=100, `theta`=0, `start` pulsed 1 cycle → 17 cycles later `done`=1 for 1 cycle, `x`=100, `y`=0, `err`=0; `busy` high for exactly 16 cycles.
- `r`=100, `theta`=2 → `x`=86, `y`=50; `r`=40, `theta`=1 → `x`=38, `y`=10; `r`=255, `theta`=3 → `x`=180, `y`=180.
- `r`=200, `theta`=6 → `x`=0, `y`=200; `r`=0, `theta`=4 → `x`=0, `y`=0; `r`=255, `theta`=0 → `x`=255, `y`=0 (no overflow).
- `theta`=9, `r`=77 → `x`=0, `y`=0, `err`=1 after the same 17-cycle latency. A following valid request clears `err` to 0 at its `done`.
- `start` held high continuously with `r`=100, `theta`=2 → `done` pulses every 18 cycles. `start` toggled and `r` changed during `busy` have no effect on the results.
- `reset_n` driven low 5 cycles into a conversion → `busy`, `done`, `x`, `y` and `err` are 0 immediately and no `done` pulse occurs. After release, `start` with `r`=100, `theta`=5 → `x`=25, `y`=96.
